// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller:
// stall vectors, multi-cycle FSM states and the zero word.
package pipe_stall_ctrl_pkg;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_MULTI = 1'b1
   } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: tracks elapsed cycles of a
// madd/msub/div op, freezes on MEM hold, aborts on flush.
module pipe_stall_ctrl_mc_seq
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MC_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mc_start,
   input  logic [MC_W-1:0] mc_len,
   input  logic            flush_req,
   input  logic            hold,
   output logic [MC_W-1:0] mc_cnt,
   output logic            mc_last,
   output logic            stallreq_ex
);

   mc_state_e       state_q, state_d;
   logic [MC_W-1:0] cnt_q, cnt_d;
   logic [MC_W-1:0] len_q, len_d;
   logic            long_op;

   // Lengths 0 and 1 both complete in the start cycle.
   assign long_op = mc_start && (mc_len > MC_W'(1));

   // State, elapsed count and latched op length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Next state, counter advance and completion flag.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      mc_last     = 1'b0;
      stallreq_ex = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            stallreq_ex = long_op;
            mc_last     = mc_start && !flush_req
                          && (mc_len <= MC_W'(1));
            if (long_op && !flush_req) begin
               state_d = S_MULTI;
               cnt_d   = MC_W'(1);
               len_d   = mc_len;
            end
         end
         S_MULTI: begin
            mc_last     = (cnt_q == len_q - MC_W'(1));
            stallreq_ex = !mc_last;
            if (flush_req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!hold) begin
               if (mc_last) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + MC_W'(1);
               end
            end
         end
      endcase
   end

   assign mc_cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline:
// stall priority merge, exception redirect, stall perf counter.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MC_W   = 6,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_mem,
   input  logic              mc_start,
   input  logic [MC_W-1:0]   mc_len,
   input  logic              flush_req,
   input  logic [31:0]       exc_vector,
   output logic [5:0]        stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic [MC_W-1:0]   mc_cnt,
   output logic              mc_last,
   output logic [PERF_W-1:0] perf_stall_cyc
);

   logic              stallreq_ex;
   logic [PERF_W-1:0] perf_q, perf_d;

   pipe_stall_ctrl_mc_seq #(
      .MC_W(MC_W)
   ) u_mc_seq (
      .clk        (clk),
      .rst        (rst),
      .mc_start   (mc_start),
      .mc_len     (mc_len),
      .flush_req  (flush_req),
      .hold       (stallreq_mem),
      .mc_cnt     (mc_cnt),
      .mc_last    (mc_last),
      .stallreq_ex(stallreq_ex)
   );

   // Flush wins; otherwise the furthest-down requester.
   always_comb begin
      stall = STALL_NONE;
      if (flush_req)         stall = STALL_NONE;
      else if (stallreq_mem) stall = STALL_MEM;
      else if (stallreq_ex)  stall = STALL_EX;
      else if (stallreq_id)  stall = STALL_ID;
      else if (stallreq_if)  stall = STALL_IF;
   end

   assign flush  = flush_req;
   assign new_pc = flush_req ? exc_vector : ZERO_WORD;

   // Saturating count of stalled, non-flush cycles.
   always_comb begin
      perf_d = perf_q;
      if ((stall != STALL_NONE) && !flush_req
          && (perf_q != {PERF_W{1'b1}}))
         perf_d = perf_q + PERF_W'(1);
   end

   // Perf counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_q <= '0;
      else      perf_q <= perf_d;
   end

   assign perf_stall_cyc = perf_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random
// traffic checked against a remaining-cycles reference model.
module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        sif, sid, smem;
   logic        start;
   logic [5:0]  len;
   logic        freq;
   logic [31:0] vec;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b;
   logic [31:0] pc_a, pc_b;
   logic [5:0]  cnt_a, cnt_b;
   logic        last_a, last_b;
   logic [31:0] perf_a;
   logic [3:0]  perf_b;

   int checks   = 0;
   int failures = 0;

   // reference model: cycles left after the current one
   int     m_rem  = 0;
   int     m_len  = 0;
   longint m_perf = 0;

   pipe_stall_ctrl dut_a (
      .clk(clk), .rst(rst),
      .stallreq_if(sif), .stallreq_id(sid),
      .stallreq_mem(smem), .mc_start(start),
      .mc_len(len), .flush_req(freq),
      .exc_vector(vec), .stall(stall_a),
      .flush(flush_a), .new_pc(pc_a),
      .mc_cnt(cnt_a), .mc_last(last_a),
      .perf_stall_cyc(perf_a)
   );

   pipe_stall_ctrl #(.MC_W(6), .PERF_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .stallreq_if(sif), .stallreq_id(sid),
      .stallreq_mem(smem), .mc_start(start),
      .mc_len(len), .flush_req(freq),
      .exc_vector(vec), .stall(stall_b),
      .flush(flush_b), .new_pc(pc_b),
      .mc_cnt(cnt_b), .mc_last(last_b),
      .perf_stall_cyc(perf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // check one cycle against the model, then advance it
   task automatic step();
      int         l;
      bit         busy, last_e, ex_e;
      logic [5:0] st_e;
      int         elapsed;
      longint     sat_b;
      #1;
      l       = int'(len);
      busy    = (m_rem > 0);
      elapsed = busy ? (m_len - m_rem) : 0;
      if (busy) last_e = (m_rem == 1);
      else      last_e = start && !freq && (l <= 1);
      if (busy) ex_e = !last_e;
      else      ex_e = start && (l > 1);
      if (freq)      st_e = 6'b000000;
      else if (smem) st_e = 6'b011111;
      else if (ex_e) st_e = 6'b001111;
      else if (sid)  st_e = 6'b000111;
      else if (sif)  st_e = 6'b000011;
      else           st_e = 6'b000000;
      sat_b = (m_perf > 15) ? 15 : m_perf;
      chk("stall", 32'(stall_a), 32'(st_e));
      chk("flush", 32'(flush_a), 32'(freq));
      chk("new_pc", pc_a, freq ? vec : 32'h0);
      chk("mc_cnt", 32'(cnt_a), 32'(elapsed));
      chk("mc_last", 32'(last_a), 32'(last_e));
      chk("perf", perf_a, 32'(m_perf));
      chk("stall_b", 32'(stall_b), 32'(st_e));
      chk("perf_b", 32'(perf_b), 32'(sat_b));
      @(posedge clk);
      if (st_e != 6'b0 && !freq) m_perf++;
      if (freq) begin
         m_rem = 0;
      end else if (busy) begin
         if (!smem) m_rem--;
      end else if (start && l > 1) begin
         m_len = l;
         m_rem = l - 1;
      end
      #1;
   endtask

   task automatic idle_in();
      sif = 0; sid = 0; smem = 0;
      start = 0; len = '0; freq = 0; vec = '0;
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      #12;
      chk("rst_stall", 32'(stall_a), 32'h0);
      chk("rst_cnt", 32'(cnt_a), 32'h0);
      chk("rst_perf", perf_a, 32'h0);
      chk("rst_last", 32'(last_a), 32'h0);
      chk("rst_newpc", pc_a, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      // priority
      sif = 1; sid = 1; smem = 1; step();
      chk("prio_all", 32'(stall_a), 32'h1f);
      sid = 0; smem = 0; step();
      sif = 0; sid = 1; step();
      idle_in(); step();

      // 4-cycle op
      start = 1; len = 6'd4; step();
      idle_in();
      repeat (4) step();

      // single-cycle op and len 0
      start = 1; len = 6'd1; step();
      start = 1; len = 6'd0; step();
      idle_in(); step();

      // MEM hold at cnt 2
      start = 1; len = 6'd4; step();
      idle_in(); step();
      smem = 1; repeat (3) step();
      smem = 0; repeat (3) step();

      // flush at cnt 2
      start = 1; len = 6'd4; step();
      idle_in(); step();
      freq = 1; vec = 32'h0000_0020; step();
      idle_in(); step();
      chk("post_flush_cnt", 32'(cnt_a), 32'h0);
      freq = 1; vec = 32'h0000_0040;
      start = 1; len = 6'd5; step();
      idle_in(); step();

      // async reset mid-op at cnt 5
      start = 1; len = 6'd10; step();
      idle_in(); repeat (4) step();
      chk("pre_rst_cnt", 32'(cnt_a), 32'h5);
      #1 rst = 1'b0;
      #1;
      chk("arst_stall", 32'(stall_a), 32'h0);
      chk("arst_cnt", 32'(cnt_a), 32'h0);
      chk("arst_perf", perf_a, 32'h0);
      chk("arst_perf_b", 32'(perf_b), 32'h0);
      m_rem  = 0;
      m_perf = 0;
      @(posedge clk);
      #1 rst = 1'b1;

      // perf saturation on the 4-bit instance
      sif = 1; repeat (20) step();
      chk("perf_sat", 32'(perf_b), 32'hf);
      idle_in(); step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         sif  = ($urandom_range(0, 3) == 0);
         sid  = ($urandom_range(0, 4) == 0);
         smem = ($urandom_range(0, 5) == 0);
         freq = ($urandom_range(0, 15) == 0);
         vec  = $urandom;
         start = (m_rem == 0)
                 && ($urandom_range(0, 3) == 0);
         len  = 6'($urandom_range(0, 7));
         step();
      end
      idle_in(); step();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
